// File: rtl/ldpc_pkg.sv
// Shared constants, the default parity-check matrix and the FSM state encoding
// for the hard-decision bit-flipping LDPC decoder.
// H_DEFAULT holds the same rows as the H_FILE list, so the netlist needs no file I/O.
package ldpc_pkg;

   localparam int N        = 11;
   localparam int K        = 6;
   localparam int M        = N - K;
   localparam int MAX_ITER = 4;
   localparam string H_FILE = "../h1.list";

   localparam int ITER_W = $clog2(MAX_ITER + 1);
   localparam int CNT_W  = $clog2(M + 1);
   localparam int ROW_W  = (M > 1) ? $clog2(M) : 1;

   // Row r of H, MSB = codeword bit N-1. Info columns 10..5 have weight >= 2
   // and are pairwise distinct; parity columns 4..0 form the identity.
   localparam logic [M-1:0][N-1:0] H_DEFAULT = {
      11'b00011110000,   // row 4
      11'b01101001000,   // row 3
      11'b10010000100,   // row 2
      11'b10100000010,   // row 1
      11'b11000100001    // row 0
   };

   typedef enum logic [2:0] {
      IDLE,
      SYNDROME,
      CHECK,
      FLIP,
      DONE
   } state_t;

endpackage

// File: rtl/ldpc_unsat_counter.sv
// Combinational unsatisfied-check counter: for each codeword bit counts the
// failing parity rows it participates in, finds the maximum count and marks
// every bit that reaches it as a flip candidate.
module ldpc_unsat_counter
   import ldpc_pkg::*;
(
   input  logic [M-1:0][N-1:0] h,
   input  logic [M-1:0]        s,
   output logic [CNT_W-1:0]    umax,
   output logic [N-1:0]        flip
);

   logic [N-1:0][CNT_W-1:0] u;

   // Per-bit popcount of failing rows, running max, then the equal-to-max mask.
   always_comb begin
      u    = '0;
      umax = '0;
      flip = '0;
      for (int j = 0; j < N; j++) begin
         for (int r = 0; r < M; r++) begin
            u[j] = u[j] + CNT_W'(h[r][j] & s[r]);
         end
         if (u[j] > umax) umax = u[j];
      end
      // A zero max would flip every bit; guard it even though a nonzero
      // syndrome with nonzero rows never produces it.
      for (int j = 0; j < N; j++) begin
         flip[j] = (u[j] == umax) && (umax != '0);
      end
   end

endmodule

// File: rtl/ldpc_bitflip_decoder.sv
// Hard-decision bit-flipping LDPC decoder. Computes the syndrome one H row per
// cycle, flips the most-suspect bits, and repeats until the syndrome clears or
// MAX_ITER flips have been spent.
// Optional: define LDPC_SYNDROME_OUT_EN to expose the final syndrome on o_syndrome.
module ldpc_bitflip_decoder
   import ldpc_pkg::*;
#(
   parameter logic [M-1:0][N-1:0] H_ROWS = H_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [N-1:0]      i_codeword,
   output logic              o_valid,
   output logic [K-1:0]      o_info_bits,
   output logic              o_success,
`ifdef LDPC_SYNDROME_OUT_EN
   output logic [M-1:0]      o_syndrome,
`endif
   output logic [ITER_W-1:0] o_iters
);

   state_t              state;
   logic [N-1:0]        cw;
   logic [M-1:0]        s;
   logic [ROW_W-1:0]    row;
   logic [ITER_W-1:0]   iter;
   logic                pass;
   logic [CNT_W-1:0]    umax;
   logic [N-1:0]        flip;

   ldpc_unsat_counter u_unsat (
      .h    (H_ROWS),
      .s    (s),
      .umax (umax),
      .flip (flip)
   );

   // Decode FSM with all outputs registered; o_valid is a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         o_ready     <= 1'b1;
         o_valid     <= 1'b0;
         o_info_bits <= '0;
         o_success   <= 1'b0;
         o_iters     <= '0;
`ifdef LDPC_SYNDROME_OUT_EN
         o_syndrome  <= '0;
`endif
         cw          <= '0;
         s           <= '0;
         row         <= '0;
         iter        <= '0;
         pass        <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               // o_ready is high throughout IDLE, so i_valid alone is a transfer.
               if (i_valid) begin
                  cw      <= i_codeword;
                  s       <= '0;
                  row     <= '0;
                  iter    <= '0;
                  o_ready <= 1'b0;
                  state   <= SYNDROME;
               end
            end
            SYNDROME: begin
               s[row] <= ^(H_ROWS[row] & cw);
               if (row == ROW_W'(M - 1)) begin
                  state <= CHECK;
               end else begin
                  row <= row + 1'b1;
               end
            end
            CHECK: begin
               if (s == '0) begin
                  pass  <= 1'b1;
                  state <= DONE;
               end else if (iter == ITER_W'(MAX_ITER)) begin
                  pass  <= 1'b0;
                  state <= DONE;
               end else begin
                  state <= FLIP;
               end
            end
            FLIP: begin
               if (umax != '0) cw <= cw ^ flip;
               iter  <= iter + 1'b1;
               row   <= '0;
               state <= SYNDROME;
            end
            DONE: begin
               o_valid     <= 1'b1;
               o_info_bits <= cw[N-1:N-K];
               o_success   <= pass;
               o_iters     <= iter;
`ifdef LDPC_SYNDROME_OUT_EN
               o_syndrome  <= s;
`endif
               o_ready     <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ldpc_bitflip_decoder.sv
// Directed testbench for ldpc_bitflip_decoder using the package H matrix.
// Expected values are hand-derived from H_DEFAULT (see per-test traces).
module tb_ldpc_bitflip_decoder;
   import ldpc_pkg::*;

   logic              clk;
   logic              rst;
   logic              i_valid;
   logic              o_ready;
   logic [N-1:0]      i_codeword;
   logic              o_valid;
   logic [K-1:0]      o_info_bits;
   logic              o_success;
   logic [ITER_W-1:0] o_iters;
`ifdef LDPC_SYNDROME_OUT_EN
   logic [M-1:0]      o_syndrome;
`endif

   int total = 0;
   int bad   = 0;

   // Codeword for info 101101: p0=0 p1=0 p2=0 p3=1 p4=0
   localparam logic [N-1:0] CW_CLEAN = 11'b10110101000;
   // Same word with bit 10 inverted; syndrome = column 10 = rows {0,1,2}
   localparam logic [N-1:0] CW_ERR10 = 11'b00110101000;
   // Bits 9 and 8 set on the zero word; flips 10 / 10,7,2 / 10,5 / 10 leave
   // final word 01110100100 with syndrome row 1 still failing.
   localparam logic [N-1:0] CW_BAD   = 11'b01100000000;

   ldpc_bitflip_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_codeword  (i_codeword),
      .o_valid     (o_valid),
      .o_info_bits (o_info_bits),
      .o_success   (o_success),
`ifdef LDPC_SYNDROME_OUT_EN
      .o_syndrome  (o_syndrome),
`endif
      .o_iters     (o_iters)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one word (assumes called #1 after a posedge with the DUT idle) and
   // waits a bounded number of edges for o_valid. lat = -1 on timeout.
   task automatic run_decode(input logic [N-1:0] cw, output int lat,
                             output logic [K-1:0] info, output logic succ,
                             output logic [ITER_W-1:0] it, output logic [M-1:0] syn,
                             output logic pulse_ok);
      lat = -1; info = '0; succ = 1'b0; it = '0; syn = '0; pulse_ok = 1'b0;
      i_codeword = cw;
      i_valid    = 1'b1;
      @(posedge clk); #1;
      i_valid    = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk); #1;
         if (o_valid) begin
            lat  = n;
            info = o_info_bits;
            succ = o_success;
            it   = o_iters;
`ifdef LDPC_SYNDROME_OUT_EN
            syn  = o_syndrome;
`endif
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk); #1;
         pulse_ok = !o_valid && o_ready;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; i_valid = 1'b0; i_codeword = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
      total++; if (o_info_bits !== '0) begin bad++; $display("FAIL reset_info got=%b want=0", o_info_bits); end
      total++; if (o_success !== 1'b0) begin bad++; $display("FAIL reset_success got=%b want=0", o_success); end
      total++; if (o_iters !== '0) begin bad++; $display("FAIL reset_iters got=%0d want=0", o_iters); end
   endtask

   task automatic test_zero_word;
      int lat; logic [K-1:0] info; logic succ; logic [ITER_W-1:0] it; logic [M-1:0] syn; logic pk;
      run_decode('0, lat, info, succ, it, syn, pk);
      total++; if (lat != 7) begin bad++; $display("FAIL zero_latency got=%0d want=7", lat); end
      total++; if (info !== 6'b000000) begin bad++; $display("FAIL zero_info got=%b want=000000", info); end
      total++; if (succ !== 1'b1) begin bad++; $display("FAIL zero_success got=%b want=1", succ); end
      total++; if (it !== 3'd0) begin bad++; $display("FAIL zero_iters got=%0d want=0", it); end
      total++; if (pk !== 1'b1) begin bad++; $display("FAIL zero_pulse got=%b want=1", pk); end
   endtask

   task automatic test_clean_word;
      int lat; logic [K-1:0] info; logic succ; logic [ITER_W-1:0] it; logic [M-1:0] syn; logic pk;
      run_decode(CW_CLEAN, lat, info, succ, it, syn, pk);
      total++; if (lat != 7) begin bad++; $display("FAIL clean_latency got=%0d want=7", lat); end
      total++; if (info !== 6'b101101) begin bad++; $display("FAIL clean_info got=%b want=101101", info); end
      total++; if (succ !== 1'b1) begin bad++; $display("FAIL clean_success got=%b want=1", succ); end
      total++; if (it !== 3'd0) begin bad++; $display("FAIL clean_iters got=%0d want=0", it); end
`ifdef LDPC_SYNDROME_OUT_EN
      total++; if (syn !== 5'b00000) begin bad++; $display("FAIL clean_syndrome got=%b want=00000", syn); end
`endif
   endtask

   task automatic test_single_error;
      int lat; logic [K-1:0] info; logic succ; logic [ITER_W-1:0] it; logic [M-1:0] syn; logic pk;
      run_decode(CW_ERR10, lat, info, succ, it, syn, pk);
      total++; if (lat != 14) begin bad++; $display("FAIL err10_latency got=%0d want=14", lat); end
      total++; if (info !== 6'b101101) begin bad++; $display("FAIL err10_info got=%b want=101101", info); end
      total++; if (succ !== 1'b1) begin bad++; $display("FAIL err10_success got=%b want=1", succ); end
      total++; if (it !== 3'd1) begin bad++; $display("FAIL err10_iters got=%0d want=1", it); end
   endtask

   task automatic test_uncorrectable;
      int lat; logic [K-1:0] info; logic succ; logic [ITER_W-1:0] it; logic [M-1:0] syn; logic pk;
      run_decode(CW_BAD, lat, info, succ, it, syn, pk);
      total++; if (lat != 35) begin bad++; $display("FAIL bad_latency got=%0d want=35", lat); end
      total++; if (succ !== 1'b0) begin bad++; $display("FAIL bad_success got=%b want=0", succ); end
      total++; if (it !== 3'd4) begin bad++; $display("FAIL bad_iters got=%0d want=4", it); end
      total++; if (info !== 6'b011101) begin bad++; $display("FAIL bad_info got=%b want=011101", info); end
`ifdef LDPC_SYNDROME_OUT_EN
      total++; if (syn !== 5'b00010) begin bad++; $display("FAIL bad_syndrome got=%b want=00010", syn); end
`endif
   endtask

   task automatic test_reset_mid_decode;
      int lat; logic [K-1:0] info; logic succ; logic [ITER_W-1:0] it; logic [M-1:0] syn; logic pk;
      int seen;
      i_codeword = CW_CLEAN;
      i_valid    = 1'b1;
      @(posedge clk); #1;          // accepting edge
      i_valid    = 1'b0;
      @(posedge clk); #1;          // SYNDROME row 1
      @(posedge clk); #1;          // now in third SYNDROME cycle
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", o_ready); end
      total++; if (o_info_bits !== '0 || o_success !== 1'b0 || o_iters !== '0)
         begin bad++; $display("FAIL midrst_outputs got=%b/%b/%0d want=0/0/0", o_info_bits, o_success, o_iters); end
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (o_valid) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_valid got=%0d want=0", seen); end
      run_decode(CW_ERR10, lat, info, succ, it, syn, pk);
      total++; if (lat != 14 || info !== 6'b101101 || succ !== 1'b1 || it !== 3'd1)
         begin bad++; $display("FAIL midrst_redecode got=lat%0d %b %b %0d want=lat14 101101 1 1", lat, info, succ, it); end
   endtask

   task automatic test_back_to_back;
      int t, acc_a, acc_b, res_n;
      int res_t[2];
      logic [K-1:0] res_info[2];
      logic res_succ[2];
      logic [ITER_W-1:0] res_it[2];
      logic rdy;
      acc_a = -1; acc_b = -1; res_n = 0; t = 0;
      res_t[0] = -1; res_t[1] = -1;
      res_info[0] = '0; res_info[1] = '0; res_succ[0] = 0; res_succ[1] = 0;
      res_it[0] = '0; res_it[1] = '0;
      i_codeword = CW_CLEAN;
      i_valid    = 1'b1;
      while (res_n < 2 && t < 80) begin
         rdy = o_ready;
         @(posedge clk); #1;
         t++;
         if (rdy && i_valid) begin
            if (acc_a < 0) begin acc_a = t; i_codeword = CW_ERR10; end
            else begin acc_b = t; i_valid = 1'b0; end
         end
         if (o_valid) begin
            res_t[res_n] = t; res_info[res_n] = o_info_bits;
            res_succ[res_n] = o_success; res_it[res_n] = o_iters;
            res_n++;
         end
      end
      i_valid = 1'b0;
      total++; if (res_n != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", res_n); end
      total++; if (acc_b - acc_a != 8) begin bad++; $display("FAIL b2b_spacing got=%0d want=8", acc_b - acc_a); end
      total++; if (res_t[0] - acc_a != 7) begin bad++; $display("FAIL b2b_lat_a got=%0d want=7", res_t[0] - acc_a); end
      total++; if (res_t[1] - acc_b != 14) begin bad++; $display("FAIL b2b_lat_b got=%0d want=14", res_t[1] - acc_b); end
      total++; if (res_info[0] !== 6'b101101 || res_succ[0] !== 1'b1 || res_it[0] !== 3'd0)
         begin bad++; $display("FAIL b2b_res_a got=%b %b %0d want=101101 1 0", res_info[0], res_succ[0], res_it[0]); end
      total++; if (res_info[1] !== 6'b101101 || res_succ[1] !== 1'b1 || res_it[1] !== 3'd1)
         begin bad++; $display("FAIL b2b_res_b got=%b %b %0d want=101101 1 1", res_info[1], res_succ[1], res_it[1]); end
   endtask

   initial begin
      $display("H matrix source: %s", H_FILE);
      test_reset;
      test_zero_word;
      test_clean_word;
      test_single_error;
      test_uncorrectable;
      test_reset_mid_decode;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
